// File: rtl/serial_to_parallel.sv
// Serial-to-parallel byte assembler for the UART receive path.
// Packs N/8 bytes MSB-first into one word behind a valid/ready holding register.
module serial_to_parallel #(
    parameter int N       = 16,
    parameter int CNTW    = 2,
    parameter int TIMEOUT = 0,
    parameter int TOW     = 24
) (
    input  logic         iCE_CLK,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         word_ready,
    input  logic         clear_err,
    output logic [N-1:0] word,
    output logic         word_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout_err
);

    localparam int NBYTES = N / 8;
    localparam logic [CNTW-1:0] LAST = CNTW'(NBYTES - 1);
    localparam logic [TOW-1:0] LIM =
        TOW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nx;
    logic [TOW-1:0]  timer;
    logic [TOW-1:0]  timer_nx;
    logic [N-1:0]    shreg;
    logic [N-1:0]    assembled;
    logic            complete;
    logic            expire;
    logic            accept_word;
    logic            drop_word;

    // The incoming byte always enters at the bottom; older bytes move up.
    generate
        if (N > 8) begin : g_wide
            assign assembled = {shreg[N-9:0], rx_byte};
        end else begin : g_byte
            assign assembled = rx_byte;
        end
    endgenerate

    assign busy        = (state == COLLECT);
    assign accept_word = complete & (~word_valid | word_ready);
    assign drop_word   = complete & word_valid & ~word_ready;

    // Control state, byte count and idle timer registers.
    always_ff @(posedge iCE_CLK) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            timer <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            timer <= timer_nx;
        end
    end

    // Next-state logic: byte counting, word completion and idle timeout.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        timer_nx = timer;
        complete = 1'b0;
        expire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    timer_nx = '0;
                    if (cnt == LAST) begin
                        complete = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx   = CNTW'(1);
                        state_nx = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    timer_nx = '0;
                    if (cnt == LAST) begin
                        complete = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + CNTW'(1);
                    end
                end else begin
                    timer_nx = timer + TOW'(1);
                    if ((TIMEOUT != 0) && (timer == LIM)) begin
                        expire   = 1'b1;
                        cnt_nx   = '0;
                        timer_nx = '0;
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    // Shift register, output holding register and error flags.
    always_ff @(posedge iCE_CLK) begin
        if (reset) begin
            shreg       <= '0;
            word        <= '0;
            word_valid  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (rx_valid) begin
                shreg <= assembled;
            end
            if (accept_word) begin
                word       <= assembled;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (drop_word) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            timeout_err <= expire;
        end
    end

endmodule
